// File: rtl/ntt_bf_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_bf_scheduler_pkg
// Description : Shared NTT constants: transform defaults, in-flight limit and
//               the scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_bf_scheduler_pkg;

    // Transform defaults
    localparam int c_n_default       = 256;
    localparam int c_logn_default    = 8;
    localparam int c_max_out_default = 4;

    // Width of the outstanding-butterfly counter (holds 0..15)
    localparam int c_out_w = 4;

    // Scheduler state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_issue = 2'd1;
    localparam state_t c_st_drain = 2'd2;
    localparam state_t c_st_done  = 2'd3;

endpackage : ntt_bf_scheduler_pkg
`default_nettype wire

// File: rtl/ntt_idx_counter.sv
`default_nettype none
// ============================================================================
// Module      : ntt_idx_counter
// Description : Nested Cooley-Tukey index walker. len halves per stage,
//               group base steps by 2*len, offset walks 0..len-1, and the
//               twiddle index m bumps once per finished group.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_idx_counter
    import ntt_bf_scheduler_pkg::*;
#(
    parameter int N    = c_n_default,
    parameter int LOGN = c_logn_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    output logic [LOGN-1:0] addr_x,
    output logic [LOGN-1:0] addr_y,
    output logic [LOGN-1:0] tf_addr,
    output logic [2:0]      stage,
    output logic            last_in_stage,
    output logic            sched_end
);

    localparam logic [LOGN:0]   c_n_ext    = (LOGN+1)'(N);
    localparam logic [LOGN-1:0] c_len_init = LOGN'(N / 2);

    logic [LOGN-1:0] len_q,  len_d;
    logic [LOGN-1:0] base_q, base_d;
    logic [LOGN-1:0] off_q,  off_d;
    logic [LOGN-1:0] m_q,    m_d;
    logic [2:0]      stage_q, stage_d;

    logic            w_grp_end;
    logic            w_stage_end;
    logic [LOGN:0]   w_base_next;

    // Group / stage boundary detection; base arithmetic is one bit wider
    // because base + 2*len reaches N on the last group of a stage.
    always_comb begin
        w_grp_end   = (off_q == (len_q - LOGN'(1)));
        w_base_next = {1'b0, base_q} + ({1'b0, len_q} << 1);
        w_stage_end = (w_base_next == c_n_ext);
    end

    // Next-index computation: clear reloads the first stage, advance steps
    always_comb begin
        len_d   = len_q;
        base_d  = base_q;
        off_d   = off_q;
        m_d     = m_q;
        stage_d = stage_q;
        if (clear) begin
            len_d   = c_len_init;
            base_d  = '0;
            off_d   = '0;
            m_d     = '0;
            stage_d = '0;
        end else if (advance) begin
            if (w_grp_end) begin
                off_d = '0;
                m_d   = m_q + LOGN'(1);
                if (w_stage_end) begin
                    base_d  = '0;
                    len_d   = len_q >> 1;
                    stage_d = stage_q + 3'd1;
                end else begin
                    base_d = w_base_next[LOGN-1:0];
                end
            end else begin
                off_d = off_q + LOGN'(1);
            end
        end
    end

    // Index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            base_q  <= '0;
            off_q   <= '0;
            m_q     <= '0;
            stage_q <= '0;
        end else begin
            len_q   <= len_d;
            base_q  <= base_d;
            off_q   <= off_d;
            m_q     <= m_d;
            stage_q <= stage_d;
        end
    end

    // Address outputs derived from the walker state
    always_comb begin
        addr_x        = base_q + off_q;
        addr_y        = base_q + off_q + len_q;
        tf_addr       = m_q + LOGN'(1);
        stage         = stage_q;
        last_in_stage = w_grp_end && w_stage_end;
        // len has been halved past 1 once the final stage has been issued
        sched_end     = (len_q == '0);
    end

endmodule : ntt_idx_counter
`default_nettype wire

// File: rtl/ntt_bf_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ntt_bf_scheduler
// Description : Forward NTT butterfly scheduler. Issues (j, j+len, m+1)
//               triples in Cooley-Tukey order, limits butterflies in flight,
//               and drains all writebacks between stages.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_bf_scheduler
    import ntt_bf_scheduler_pkg::*;
#(
    parameter int N       = c_n_default,
    parameter int LOGN    = c_logn_default,
    parameter int MAX_OUT = c_max_out_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            bf_valid,
    input  logic            bf_ready,
    output logic [LOGN-1:0] addr_x,
    output logic [LOGN-1:0] addr_y,
    output logic [LOGN-1:0] tf_addr,
    output logic [2:0]      stage,
    input  logic            wb_done,
    output logic            err
);

    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUT);

    state_t             state_q, state_d;
    logic [c_out_w-1:0] outstanding_q, outstanding_d;
    logic               err_q, err_d;

    logic               w_start_acc;
    logic               w_issue_hs;
    logic               w_active;
    logic [LOGN-1:0]    w_cnt_x;
    logic [LOGN-1:0]    w_cnt_y;
    logic [LOGN-1:0]    w_cnt_tf;
    logic [2:0]         w_cnt_stage;
    logic               w_last_in_stage;
    logic               w_sched_end;

    ntt_idx_counter #(
        .N    (N),
        .LOGN (LOGN)
    ) u_idx (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_start_acc),
        .advance       (w_issue_hs),
        .addr_x        (w_cnt_x),
        .addr_y        (w_cnt_y),
        .tf_addr       (w_cnt_tf),
        .stage         (w_cnt_stage),
        .last_in_stage (w_last_in_stage),
        .sched_end     (w_sched_end)
    );

    // State, in-flight count and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= c_st_idle;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (start) state_d = c_st_issue;
            end
            c_st_issue: begin
                if (w_issue_hs && w_last_in_stage) state_d = c_st_drain;
            end
            c_st_drain: begin
                // Hold the next stage until every result of this one is back
                if (outstanding_q == '0) begin
                    state_d = w_sched_end ? c_st_done : c_st_issue;
                end
            end
            c_st_done: begin
                state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    // In-flight counter and error flag; a spurious writeback is flagged
    // and the counter is pinned at zero rather than wrapping.
    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (w_start_acc) err_d = 1'b0;
        if (w_issue_hs && !wb_done) begin
            outstanding_d = outstanding_q + c_out_w'(1);
        end else if (wb_done && !w_issue_hs) begin
            if (outstanding_q == '0) begin
                err_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - c_out_w'(1);
            end
        end
    end

    // Outputs; index ports read zero outside an active schedule
    always_comb begin
        w_start_acc = (state_q == c_st_idle) && start;
        w_active    = (state_q == c_st_issue) || (state_q == c_st_drain);
        bf_valid    = (state_q == c_st_issue) && (outstanding_q < c_max_out);
        w_issue_hs  = bf_valid && bf_ready;
        busy        = w_active;
        done        = (state_q == c_st_done);
        err         = err_q;
        addr_x      = w_active ? w_cnt_x     : '0;
        addr_y      = w_active ? w_cnt_y     : '0;
        tf_addr     = w_active ? w_cnt_tf    : '0;
        stage       = w_active ? w_cnt_stage : '0;
    end

endmodule : ntt_bf_scheduler
`default_nettype wire

// File: tb/tb_ntt_bf_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_bf_scheduler
// Description : Self-checking bench for ntt_bf_scheduler. A reference table of
//               the full Cooley-Tukey issue order is built from nested loops;
//               randomized ready/writeback behaviour is driven around it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_bf_scheduler;

    localparam int c_n     = 256;
    localparam int c_logn  = 8;
    localparam int c_max   = 4;
    localparam int c_total = (c_n / 2) * c_logn;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              bf_valid;
    logic              bf_ready;
    logic [c_logn-1:0] addr_x;
    logic [c_logn-1:0] addr_y;
    logic [c_logn-1:0] tf_addr;
    logic [2:0]        stage;
    logic              wb_done;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_tab [0:c_total-1];
    logic [31:0] w_obs;

    ntt_bf_scheduler #(
        .N       (c_n),
        .LOGN    (c_logn),
        .MAX_OUT (c_max)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bf_valid (bf_valid),
        .bf_ready (bf_ready),
        .addr_x   (addr_x),
        .addr_y   (addr_y),
        .tf_addr  (tf_addr),
        .stage    (stage),
        .wb_done  (wb_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack(input int x, input int y, input int tf, input int st);
        logic [7:0] bx, by, btf;
        logic [2:0] bst;
        bx  = 8'(x);
        by  = 8'(y);
        btf = 8'(tf);
        bst = 3'(st);
        return {5'd0, bx, by, btf, bst};
    endfunction

    assign w_obs = {5'd0, addr_x, addr_y, tf_addr, stage};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Full issue order straight from the Cooley-Tukey loop nest
    task automatic build_table();
        int k = 0;
        int m = 0;
        for (int s = 0; s < c_logn; s++) begin
            int len = (c_n / 2) >> s;
            for (int st = 0; st <= c_n - 2 * len; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    exp_tab[k] = pack(j, j + len, m + 1, s);
                    k++;
                end
                m++;
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, {28'd0, busy, done, bf_valid, err}, 32'd0);
        chk(tag, w_obs, 32'd0);
    endtask

    // One schedule with random ready and writeback latency in [dmin,dmax].
    // stall_at >= 0: hold ready low 5 cycles while issue stall_at is offered.
    // abort_at >= 0: pulse rst (with a wb_done) when that issue is next.
    task automatic run_sched(input int rdy_pct, input int dmin, input int dmax,
                             input int stall_at, input int abort_at);
        int          idx       = 0;
        int          out_m     = 0;
        int          out_b     = 0;
        int          dones     = 0;
        int          stall_cnt = 0;
        int          last_st   = 0;
        int          due_q[$];
        logic        prev_hold = 1'b0;
        logic [31:0] prev_obs  = '0;
        logic        fin       = 1'b0;
        logic        rdy;
        logic        wb;

        @(negedge clk);
        start = 1'b1; bf_ready = 1'b0; wb_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", 32'(bf_valid), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_after_start", 32'(err), 32'd0);

        for (int c = 0; c < 30000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                dones++;
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_after_all", 32'(idx), 32'(c_total));
                fin = 1'b1;
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(bf_valid), 32'd1);
                chk("hold_outputs", w_obs, prev_obs);
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1; wb_done = 1'b1; bf_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0; wb_done = 1'b0;
                chk_reset_state("abort_reset_state");
                chk("abort_no_done", 32'(dones), 32'd0);
                return;
            end
            wb = (due_q.size() > 0) && (due_q[0] <= cyc);
            if (idx == stall_at && stall_cnt < 5 && bf_valid) begin
                rdy = 1'b0;
                stall_cnt++;
                chk("stall_outputs", w_obs, exp_tab[stall_at]);
            end else begin
                rdy = (int'($urandom_range(99)) < rdy_pct);
            end
            bf_ready = rdy;
            wb_done  = wb;
            out_b    = out_m;
            if (wb) begin
                void'(due_q.pop_front());
                out_m--;
            end
            if (bf_valid) chk("valid_under_limit", 32'(out_b < c_max), 32'd1);
            if (bf_valid && rdy) begin
                if (idx >= c_total) begin
                    chk("extra_issue", 32'(idx), 32'(c_total - 1));
                end else begin
                    chk("issue", w_obs, exp_tab[idx]);
                    if (int'(exp_tab[idx][2:0]) != last_st) begin
                        chk("stage_drained", 32'(out_b), 32'd0);
                        last_st = int'(exp_tab[idx][2:0]);
                    end
                end
                due_q.push_back(cyc + 1 + int'($urandom_range(dmax - dmin)) + dmin - 1);
                out_m++;
                idx++;
            end
            prev_hold = bf_valid && !rdy;
            prev_obs  = w_obs;
        end
        bf_ready = 1'b0; wb_done = 1'b0;
        chk("sched_finished", 32'(fin), 32'd1);
        chk("issue_count", 32'(idx), 32'(c_total));
        chk("writebacks_all_back", 32'(due_q.size()), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", {30'd0, busy, bf_valid}, 32'd0);
        chk("err_clean_run", 32'(err), 32'd0);
        chk("done_pulses", 32'(dones), 32'd1);
    endtask

    // Withheld writebacks: in-flight limit, then one return releases one issue
    task automatic run_withheld();
        int hs = 0;
        @(negedge clk);
        start = 1'b1; bf_ready = 1'b0; wb_done = 1'b0;
        @(negedge clk);
        start = 1'b0; bf_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            if (bf_valid) begin
                chk("wh_issue", w_obs, exp_tab[hs]);
                hs++;
            end
        end
        chk("wh_limit_count", 32'(hs), 32'(c_max));
        @(negedge clk);
        chk("wh_valid_low", 32'(bf_valid), 32'd0);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (bf_valid) begin
                chk("wh_issue", w_obs, exp_tab[hs]);
                hs++;
            end
        end
        chk("wh_one_more", 32'(hs), 32'(c_max + 1));
        bf_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("wh_reset_state");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bf_ready = 1'b0; wb_done = 1'b0;
        build_table();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset_state");

        // Full-rate run with single-cycle writeback
        run_sched(100, 1, 1, -1, -1);
        // Ready stall mid stage 0 at j=10
        run_sched(100, 1, 1, 10, -1);
        // In-flight limit with writebacks withheld
        run_withheld();
        // Slow writebacks across every stage boundary
        run_sched(100, 10, 10, -1, -1);
        // Random back-pressure and latency
        run_sched(70, 1, 12, -1, -1);

        // Spurious writeback while idle sets err; next start clears it
        @(negedge clk);
        wb_done = 1'b1;
        @(negedge clk);
        wb_done = 1'b0;
        chk("err_set_idle", 32'(err), 32'd1);
        run_sched(100, 1, 3, -1, -1);

        // Reset mid-run, then a clean run from the beginning
        run_sched(100, 1, 1, -1, 300);
        run_sched(100, 1, 1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ntt_bf_scheduler
`default_nettype wire

// File: doc/ntt_bf_scheduler.md
NTT_BF_SCHEDULER -- requirements
Module: ntt_bf_scheduler

Interface
REQ-001 SHALL have parameter N, default 256, transform length (power of two).
REQ-002 SHALL have parameter LOGN, default 8, log2(N) and the width of all address ports.
REQ-003 SHALL have parameter MAX_OUT, default 4, the maximum number of butterflies in flight (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-006 SHALL have port start, input, 1, a one-cycle request to run one full forward NTT schedule.
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when the schedule is complete.
REQ-009 SHALL have port bf_valid, output, 1, butterfly issue valid.
REQ-010 SHALL have port bf_ready, input, 1, butterfly unit accepts the issue.
REQ-011 SHALL have port addr_x, output, LOGN, memory index j.
REQ-012 SHALL have port addr_y, output, LOGN, memory index j+len.
REQ-013 SHALL have port tf_addr, output, LOGN, twiddle ROM index m+1.
REQ-014 SHALL have port stage, output, 3, current stage index, 0..LOGN-1.
REQ-015 SHALL have port wb_done, input, 1, a one-cycle pulse for each butterfly result written back.
REQ-016 SHALL have port err, output, 1, sticky protocol error flag.

Function
REQ-017 SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-018 SHALL make these transitions: IDLE->ISSUE on start; ISSUE->DRAIN after the handshake of the last butterfly of a stage; DRAIN->ISSUE when outstanding==0 and len>1; DRAIN->DONE when outstanding==0 and len==1; DONE->IDLE unconditionally.
REQ-019 SHALL schedule in Cooley-Tukey order:
  - len runs N/2 down to 1, halving per stage.
  - start runs 0 to N-2*len, stepping by 2*len.
  - j runs start to start+len-1.
REQ-020 SHALL drive addr_x=j, addr_y=j+len and tf_addr=m+1, where m is 0 at start and increments once per completed start group across all stages.
REQ-021 SHALL issue N/2 butterflies per stage, (N/2)*LOGN in total (1024 at defaults), with tf_addr covering 1..N-1.
REQ-022 SHALL assert bf_valid only in ISSUE and only when outstanding<MAX_OUT.
REQ-023 SHALL advance to the next butterfly only on bf_valid&&bf_ready, giving at most one issue per cycle.
REQ-024 SHALL hold addr_x, addr_y, tf_addr and stage stable while bf_valid&&!bf_ready.
REQ-025 SHALL keep an outstanding counter that:
  - increments on an issue handshake;
  - decrements on wb_done;
  - stays unchanged when both occur in the same cycle.
REQ-026 SHALL wait in DRAIN for all writebacks before the first issue of the next stage (read-after-write protection between stages).
REQ-027 SHALL, on wb_done with outstanding==0, set err, leave the counter at 0 and continue the schedule.
REQ-028 SHALL ignore start while busy; the schedule is not restarted.
REQ-029 SHALL clear err when start is accepted in IDLE.
REQ-030 SHALL assert done for exactly one cycle, in DONE; busy SHALL be low in that cycle.
REQ-031 SHALL, with bf_ready held high and wb_done returning, produce its first bf_valid in the cycle after start is sampled.

Reset
REQ-032 SHALL, on rst high at a clock edge, enter IDLE with the following outputs:
  - busy=0, done=0, bf_valid=0, err=0;
  - addr_x=0, addr_y=0, tf_addr=0, stage=0;
  - outstanding counter cleared.
REQ-033 SHALL abandon any schedule in progress on reset mid-operation, with no done pulse, and SHALL ignore wb_done in the reset cycle.

Structure
REQ-034 SHALL place the state encoding, the N/LOGN defaults and the MAX_OUT default in the shared NTT package.
REQ-035 SHALL have one natural sub-module, ntt_idx_counter, the nested len/start/j/m counter with an advance input and a last-in-stage output.

Verification
REQ-036 SHALL cover start with bf_ready=1 and wb_done one cycle after each issue -> first issue (0,128,1), stage-0 last (127,255,1), stage-1 issues (0,64,2) and (128,192,3), final issue (254,255,255), 1024 handshakes, one done pulse.
REQ-037 SHALL cover bf_ready low for 5 cycles mid-stage-0 at j=10 -> bf_valid high and outputs held at (10,138,1) throughout, no skipped or duplicate index.
REQ-038 SHALL cover wb_done withheld -> exactly MAX_OUT=4 issues, then bf_valid low; one wb_done -> exactly one more issue.
REQ-039 SHALL cover the stage boundary with wb_done delayed 10 cycles -> no stage-1 issue until outstanding reaches 0.
REQ-040 SHALL cover an extra wb_done while idle -> err=1; next start -> err=0.
REQ-041 SHALL cover rst at issue 300, then start -> first issue (0,128,1), with no done pulse before the new run completes.
